// File: rtl/sys_ctrl_pkg.sv
// rtl/sys_ctrl_pkg.sv - shared types and constants for the command sequencer
package sys_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        OP_A,
        OP_B,
        ALU_FUN,
        ALU_RUN,
        ALU_WAIT,
        TX_RD,
        TX_LO,
        TX_HI
    } state_t;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

endpackage

// File: rtl/sys_ctrl_tx_seq.sv
// rtl/sys_ctrl_tx_seq.sv - TX FIFO push stage with full-flag stall and byte select
//
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   req           a response byte is waiting to be pushed
//   sel_hi        1: push word[2*DATA_WIDTH-1:DATA_WIDTH], 0: push low byte
//   word          captured response word (read byte or ALU result)
//   tx_fifo_full  FIFO full flag; a push is held off while it is set
//   accept        combinational: the byte is pushed on this edge
//   tx_fifo_data  registered byte presented to the FIFO
//   tx_fifo_wr    registered one-cycle write strobe
module sys_ctrl_tx_seq #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    req,
    input  logic                    sel_hi,
    input  logic [2*DATA_WIDTH-1:0] word,
    input  logic                    tx_fifo_full,
    output logic                    accept,
    output logic [DATA_WIDTH-1:0]   tx_fifo_data,
    output logic                    tx_fifo_wr
);

    // The requesting state only advances when this is high, so a stalled
    // byte stays pending and is never dropped or pushed twice.
    assign accept = req && !tx_fifo_full;

    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_fifo_data <= '0;
            tx_fifo_wr   <= 1'b0;
        end else begin
            tx_fifo_wr <= accept;
            if (accept) begin
                tx_fifo_data <= sel_hi ? word[2*DATA_WIDTH-1:DATA_WIDTH]
                                       : word[DATA_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/sys_cmd_ctrl.sv
// rtl/sys_cmd_ctrl.sv - UART byte-command sequencer for register file, ALU and TX FIFO
//
// Optional feature: define CMD_TIMEOUT_EN to abandon a partial command after
// TIMEOUT_CYCLES idle cycles in a byte-accepting state.
//
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   rx_data, rx_valid            received byte and its one-cycle strobe
//   rf_wr_en, rf_rd_en           register-file write / read strobes
//   rf_addr, rf_wr_data          register-file address and write data
//   rf_rd_data, rf_rd_valid      register-file read data and valid strobe
//   alu_en, alu_fun              ALU start pulse and function code
//   alu_out, alu_valid           ALU result and valid strobe
//   clk_gate_en                  ALU clock-gate enable
//   tx_fifo_data, tx_fifo_wr     byte and write strobe to the TX FIFO
//   tx_fifo_full                 TX FIFO full flag
//   busy                         high whenever a command is in progress
module sys_cmd_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALU_FUN_WIDTH  = 4,
    parameter int ALU_OUT_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    rx_data,
    input  logic                     rx_valid,
    output logic                     rf_wr_en,
    output logic                     rf_rd_en,
    output logic [ADDR_WIDTH-1:0]    rf_addr,
    output logic [DATA_WIDTH-1:0]    rf_wr_data,
    input  logic [DATA_WIDTH-1:0]    rf_rd_data,
    input  logic                     rf_rd_valid,
    output logic                     alu_en,
    output logic [ALU_FUN_WIDTH-1:0] alu_fun,
    input  logic [ALU_OUT_WIDTH-1:0] alu_out,
    input  logic                     alu_valid,
    output logic                     clk_gate_en,
    output logic [DATA_WIDTH-1:0]    tx_fifo_data,
    output logic                     tx_fifo_wr,
    input  logic                     tx_fifo_full,
    output logic                     busy
);

    state_t                   state_q, state_d;
    logic                     wr_en_d, rd_en_d;
    logic [ADDR_WIDTH-1:0]    addr_d;
    logic [DATA_WIDTH-1:0]    wr_data_d;
    logic [ALU_FUN_WIDTH-1:0] fun_d;
    logic [ALU_OUT_WIDTH-1:0] resp_q, resp_d;
    logic                     tx_req, tx_sel_hi, tx_accept;

`ifdef CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            byte_state;

    assign byte_state = (state_q == WR_ADDR) || (state_q == WR_DATA) ||
                        (state_q == RD_ADDR) || (state_q == OP_A)    ||
                        (state_q == OP_B)    || (state_q == ALU_FUN);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        addr_d    = rf_addr;
        wr_data_d = rf_wr_data;
        fun_d     = alu_fun;
        resp_d    = resp_q;
        tx_req    = 1'b0;
        tx_sel_hi = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == DATA_WIDTH'(CMD_RF_WR))        state_d = WR_ADDR;
                    else if (rx_data == DATA_WIDTH'(CMD_RF_RD))   state_d = RD_ADDR;
                    else if (rx_data == DATA_WIDTH'(CMD_ALU_OP))  state_d = OP_A;
                    else if (rx_data == DATA_WIDTH'(CMD_ALU_NOP)) state_d = ALU_FUN;
                end
            end
            WR_ADDR: begin
                if (rx_valid) begin
                    addr_d  = rx_data[ADDR_WIDTH-1:0];
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (rx_valid) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = rx_data;
                    state_d   = IDLE;
                end
            end
            RD_ADDR: begin
                if (rx_valid) begin
                    addr_d  = rx_data[ADDR_WIDTH-1:0];
                    rd_en_d = 1'b1;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rf_rd_valid) begin
                    resp_d  = {{(ALU_OUT_WIDTH-DATA_WIDTH){1'b0}}, rf_rd_data};
                    state_d = TX_RD;
                end
            end
            OP_A: begin
                if (rx_valid) begin
                    wr_en_d   = 1'b1;
                    addr_d    = ADDR_WIDTH'(OPA_ADDR);
                    wr_data_d = rx_data;
                    state_d   = OP_B;
                end
            end
            OP_B: begin
                if (rx_valid) begin
                    wr_en_d   = 1'b1;
                    addr_d    = ADDR_WIDTH'(OPB_ADDR);
                    wr_data_d = rx_data;
                    state_d   = ALU_FUN;
                end
            end
            ALU_FUN: begin
                if (rx_valid) begin
                    fun_d   = rx_data[ALU_FUN_WIDTH-1:0];
                    state_d = ALU_RUN;
                end
            end
            ALU_RUN: state_d = ALU_WAIT;
            ALU_WAIT: begin
                if (alu_valid) begin
                    resp_d  = alu_out;
                    state_d = TX_LO;
                end
            end
            TX_RD: begin
                tx_req = 1'b1;
                if (tx_accept) state_d = IDLE;
            end
            TX_LO: begin
                tx_req = 1'b1;
                if (tx_accept) state_d = TX_HI;
            end
            TX_HI: begin
                tx_req    = 1'b1;
                tx_sel_hi = 1'b1;
                if (tx_accept) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef CMD_TIMEOUT_EN
        // Only fires on a cycle with no byte, so the abandoned step has
        // produced no strobes; earlier completed steps keep their effects.
        if (byte_state && !rx_valid && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1))) begin
            state_d = IDLE;
        end
`endif
    end

`ifdef CMD_TIMEOUT_EN
    always_comb begin
        to_cnt_d = '0;
        if (byte_state && !rx_valid && (state_d != IDLE)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) to_cnt_q <= '0;
        else     to_cnt_q <= to_cnt_d;
    end
`endif

    // Outputs are registered from the next state so each strobe lines up
    // with the state it belongs to (alu_en during ALU_RUN, etc.).
    always_ff @(posedge CLK) begin
        if (RST) begin
            rf_wr_en    <= 1'b0;
            rf_rd_en    <= 1'b0;
            rf_addr     <= '0;
            rf_wr_data  <= '0;
            alu_en      <= 1'b0;
            alu_fun     <= '0;
            clk_gate_en <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rf_wr_en    <= wr_en_d;
            rf_rd_en    <= rd_en_d;
            rf_addr     <= addr_d;
            rf_wr_data  <= wr_data_d;
            alu_en      <= (state_d == ALU_RUN);
            alu_fun     <= fun_d;
            clk_gate_en <= (state_d == ALU_RUN) || (state_d == ALU_WAIT);
            busy        <= (state_d != IDLE);
        end
    end

    sys_ctrl_tx_seq #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tx_seq (
        .CLK          (CLK),
        .RST          (RST),
        .req          (tx_req),
        .sel_hi       (tx_sel_hi),
        .word         (resp_q),
        .tx_fifo_full (tx_fifo_full),
        .accept       (tx_accept),
        .tx_fifo_data (tx_fifo_data),
        .tx_fifo_wr   (tx_fifo_wr)
    );

endmodule

// File: doc/sys_cmd_ctrl.md
Name: sys_cmd_ctrl

Overview:
Command sequencer between the UART receive path and the register file, ALU and TX async FIFO in the system top. It parses byte commands arriving on the RX data-valid strobe and drives register-file writes and reads. It loads ALU operands, triggers ALU operations and gates the ALU clock. It pushes response bytes (read data, 16-bit ALU result) into the TX FIFO.

Parameters:
DATA_WIDTH, 8, UART byte / register-file word width
ADDR_WIDTH, 4, register-file address width
ALU_FUN_WIDTH, 4, ALU function code width (low bits of function byte)
ALU_OUT_WIDTH, 16, ALU result width (sent as 2 bytes)
TIMEOUT_CYCLES, 65535, inter-byte timeout (used only with CMD_TIMEOUT_EN)

Ports:
CLK  in  1  system clock (REF_CLK domain)
RST  in  1  synchronous, active-high reset
rx_data  in  DATA_WIDTH  received byte from UART RX synchroniser
rx_valid  in  1  one-cycle strobe; rx_data valid (parity/stop errors never strobe)
rf_wr_en  out  1  register-file write strobe
rf_rd_en  out  1  register-file read strobe
rf_addr  out  ADDR_WIDTH  register-file address
rf_wr_data  out  DATA_WIDTH  register-file write data
rf_rd_data  in  DATA_WIDTH  register-file read data
rf_rd_valid  in  1  read data valid strobe
alu_en  out  1  one-cycle ALU start
alu_fun  out  ALU_FUN_WIDTH  ALU function code
alu_out  in  ALU_OUT_WIDTH  ALU result
alu_valid  in  1  result valid strobe
clk_gate_en  out  1  ALU clock-gate enable
tx_fifo_data  out  DATA_WIDTH  byte pushed to TX FIFO
tx_fifo_wr  out  1  TX FIFO write strobe
tx_fifo_full  in  1  TX FIFO full flag
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs registered and 0; state IDLE. A reset mid-command discards the partial command and any pending TX byte.
- Commands: 0xAA addr data = write; 0xBB addr = read; 0xCC A B fun = ALU with operands; 0xDD fun = ALU without operands (reuses RF[0], RF[1]). Any other byte in IDLE is ignored.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_RUN, ALU_WAIT, TX_RD, TX_LO, TX_HI.
- Address bytes: only bits [ADDR_WIDTH-1:0] are used; the upper bits are ignored.
- Write: the data byte accepted in WR_DATA gives rf_wr_en=1 for 1 cycle on the next edge, with the latched address. Then IDLE.
- Read: the address byte in RD_ADDR gives rf_rd_en=1 for 1 cycle, then RD_WAIT. On rf_rd_valid, data is captured and the state moves to TX_RD.
- OP_A: byte written to RF addr 0.
- OP_B: byte written to RF addr 1; next state ALU_FUN.
- ALU_FUN: fun byte latched to alu_fun (low ALU_FUN_WIDTH bits). clk_gate_en rises on the same edge.
- ALU_RUN: alu_en=1 for exactly 1 cycle, then ALU_WAIT. On alu_valid, the result is captured and the state moves to TX_LO.
- clk_gate_en is 1 in ALU_FUN (after fun byte), ALU_RUN and ALU_WAIT; 0 elsewhere.
- TX states: tx_fifo_wr pulses 1 cycle only when tx_fifo_full=0; otherwise the state holds with no write and no byte loss.
  - TX_RD sends the read byte, then IDLE.
  - TX_LO sends result[7:0], then TX_HI.
  - TX_HI sends result[15:8], then IDLE.
- rx_valid while in RD_WAIT, ALU_RUN, ALU_WAIT or TX_* is dropped. rx_valid in the cycle of return to IDLE is processed normally from the next cycle.
- Byte-accepting states ignore cycles without rx_valid, with no timeout unless the macro is defined.

Optional Feature:
CMD_TIMEOUT_EN:
- Defined: a counter is cleared on each accepted byte and increments in WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B and ALU_FUN. When it reaches TIMEOUT_CYCLES, the state returns to IDLE with no RF/ALU side effects for the incomplete step. RF writes of steps already completed (e.g. OP_A) remain.
- Undefined: no counter; a partial command waits indefinitely.

Decomposition:
- Package sys_ctrl_pkg: state enum; command constants CMD_RF_WR=8'hAA, CMD_RF_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD; operand addresses OPA_ADDR=0, OPB_ADDR=1.
- One natural sub-module: sys_ctrl_tx_seq, the FIFO push sequencer with full-flag stall and 1/2-byte select.

Test Plan:
- AA,09,A6 -> single rf_wr_en cycle, rf_addr=9, rf_wr_data=A6; busy low afterwards.
- BB,09 with rf_rd_data=A6 after 2 cycles -> rf_rd_en one cycle, addr=9; tx_fifo_wr once, data=A6.
- CC,35,88,02 with alu_out=1C28 -> writes RF0=35, RF1=88; alu_fun=2; one alu_en pulse; clk_gate_en high through ALU_WAIT; FIFO receives 28 then 1C.
- DD,08 with alu_out=00BD -> no RF writes; alu_fun=8; FIFO receives BD then 00.
- tx_fifo_full=1 for 10 cycles during TX_LO -> no tx_fifo_wr while full; bytes still delivered in order, none lost or duplicated.
- 55 in IDLE, then RST asserted mid AA,09 -> no outputs; after reset all outputs 0 and state IDLE. With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=100: AA then silence -> back to IDLE at cycle 100, no write.
